mfp_ahb_ram_slave: RTL and testbench

AHB-Lite slave RAM placed directly downstream of the MIPSfpga core's AHB-Lite master port, behind the bus matrix decode.
- Consumes the core's address/control/write-data phases.
- Returns HRDATA, HREADYOUT and HRESP.
- Has a programmable wait-state count and a write-to-read forwarding path, so back-to-back store/load sequences from the core complete correctly.

---
 rtl/mfp_ahb_ram_slave_pkg.sv | 15 +
 rtl/mfp_ahb_ram_array.sv | 21 ++
 rtl/mfp_ahb_ram_slave.sv | 99 +++++++++
 tb/tb_mfp_ahb_ram_slave.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/mfp_ahb_ram_slave_pkg.sv
// mfp_ahb_ram_slave_pkg: AHB-Lite HTRANS/HSIZE/HRESP encodings, slave state type (ERR1/ERR2 only with MFP_AHB_RAM_ERR_EN) and byte-lane helper
package mfp_ahb_ram_slave_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'd0, HTRANS_BUSY = 2'd1, HTRANS_NONSEQ = 2'd2, HTRANS_SEQ = 2'd3;
  localparam logic [2:0] HSIZE_BYTE = 3'd0, HSIZE_HALF = 3'd1, HSIZE_WORD = 3'd2;
  localparam logic HRESP_OKAY = 1'b0, HRESP_ERROR = 1'b1;
  localparam int BYTE_LANES = 4;
`ifdef MFP_AHB_RAM_ERR_EN
  typedef enum logic [1:0] {IDLE, ACCESS, ERR1, ERR2} state_t;
`else
  typedef enum logic [0:0] {IDLE, ACCESS} state_t;
`endif
  function automatic logic [3:0] byte_en(input logic [2:0] size, input logic [1:0] a);
    return size == HSIZE_BYTE ? 4'b0001 << a : size == HSIZE_HALF ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  endfunction
endpackage

// File: rtl/mfp_ahb_ram_array.sv
// mfp_ahb_ram_array: synchronous-read 32-bit word RAM with 4 byte write enables (clk; re/raddr -> rdata next cycle, read-before-write; we/be/waddr/wdata)
module mfp_ahb_ram_array
  import mfp_ahb_ram_slave_pkg::*;
#(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [31:0]           rdata,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [31:0]           wdata
);
  logic [31:0] mem [2**ADDR_WIDTH];
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
    for (int i = 0; i < BYTE_LANES; i++) if (we && be[i]) mem[waddr][8*i+:8] <= wdata[8*i+:8];
  end
endmodule

// File: rtl/mfp_ahb_ram_slave.sv
// mfp_ahb_ram_slave: AHB-Lite RAM slave with WAIT_STATES data-phase stalls and write-to-read forwarding; in HCLK/HRESETn/HSEL/HADDR/HTRANS/HWRITE/HSIZE/HBURST/HPROT/HMASTLOCK/HWDATA/HREADY, out HRDATA/HREADYOUT/HRESP; MFP_AHB_RAM_ERR_EN adds two-cycle ERROR for index>=DEPTH or HSIZE>2
module mfp_ahb_ram_slave
  import mfp_ahb_ram_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int DEPTH       = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic        HWRITE,
  input  logic [2:0]  HSIZE,
  input  logic [2:0]  HBURST,
  input  logic [3:0]  HPROT,
  input  logic        HMASTLOCK,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic [31:0] HRDATA,
  output logic        HREADYOUT,
  output logic        HRESP
);
  logic accept, err, we, unused_ok;
  logic [ADDR_WIDTH-1:0] idx, idx_q, idx_d;
  logic [31:0] ram_rdata, rd_merged;
  state_t state_q, state_d;
  logic write_q, write_d, fwd_q, fwd_d;
  logic [3:0] be_q, be_d, fwd_be_q, fwd_be_d;
  logic [2:0] wcnt_q, wcnt_d;
  logic [31:0] fwd_data_q, fwd_data_d, hrdata_q, hrdata_d;
  assign idx = HADDR[ADDR_WIDTH+1:2];
  assign accept = HSEL & HTRANS[1] & HREADY;
  assign we = state_q == ACCESS && write_q && wcnt_q == 3'd0;
  assign unused_ok = ^{HBURST, HPROT, HMASTLOCK, HTRANS[0], HADDR[31:ADDR_WIDTH+2]};
`ifdef MFP_AHB_RAM_ERR_EN
  assign err = int'(idx) >= DEPTH || HSIZE > HSIZE_WORD;
  assign HREADYOUT = state_q != ERR1 && !(state_q == ACCESS && wcnt_q != 3'd0);
  assign HRESP = state_q == ERR1 || state_q == ERR2 ? HRESP_ERROR : HRESP_OKAY;
`else
  localparam int unused_depth = DEPTH;
  assign err = 1'b0;
  assign HREADYOUT = !(state_q == ACCESS && wcnt_q != 3'd0);
  assign HRESP = HRESP_OKAY;
`endif
  assign HRDATA = state_q == ACCESS && !write_q ? rd_merged : hrdata_q;
  always_comb begin
    idx_d = accept ? idx : idx_q;
    write_d = accept ? HWRITE : write_q;
    be_d = accept ? byte_en(HSIZE, HADDR[1:0]) : be_q;
    wcnt_d = accept ? (err ? 3'd0 : 3'(WAIT_STATES)) : wcnt_q - 3'(wcnt_q != 3'd0);
    // A read accepted while a write to the same word retires sees pre-write RAM data; remember the write to patch it.
    fwd_d = accept ? we && idx_q == idx : fwd_q;
    fwd_be_d = accept ? be_q : fwd_be_q;
    fwd_data_d = accept ? HWDATA : fwd_data_q;
    rd_merged = ram_rdata;
    for (int i = 0; i < BYTE_LANES; i++) rd_merged[8*i+:8] = fwd_q && fwd_be_q[i] ? fwd_data_q[8*i+:8] : ram_rdata[8*i+:8];
    hrdata_d = state_q == ACCESS && !write_q && HREADYOUT ? rd_merged : hrdata_q;
`ifdef MFP_AHB_RAM_ERR_EN
    state_d = state_q == ERR1 ? ERR2 : !HREADYOUT ? state_q : !accept ? IDLE : err ? ERR1 : ACCESS;
`else
    state_d = !HREADYOUT ? state_q : accept ? ACCESS : IDLE;
`endif
  end
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= IDLE;
      idx_q <= '0;
      write_q <= 1'b0;
      be_q <= 4'd0;
      wcnt_q <= 3'd0;
      fwd_q <= 1'b0;
      fwd_be_q <= 4'd0;
      fwd_data_q <= 32'd0;
      hrdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      write_q <= write_d;
      be_q <= be_d;
      wcnt_q <= wcnt_d;
      fwd_q <= fwd_d;
      fwd_be_q <= fwd_be_d;
      fwd_data_q <= fwd_data_d;
      hrdata_q <= hrdata_d;
    end
  end
  mfp_ahb_ram_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk  (HCLK),
    .re   (accept),
    .raddr(idx),
    .rdata(ram_rdata),
    .we   (we),
    .be   (be_q),
    .waddr(idx_q),
    .wdata(HWDATA)
  );
endmodule

// File: tb/tb_mfp_ahb_ram_slave.sv
// tb_mfp_ahb_ram_slave: scoreboard bench driving a WAIT_STATES=0 and a WAIT_STATES=3 slave over a shared AHB-Lite bus
module tb_mfp_ahb_ram_slave;
  import mfp_ahb_ram_slave_pkg::*;
  typedef struct {logic wr; logic [31:0] d; logic er;} exp_t;
  exp_t sb[$];
  exp_t e;
  logic clk = 1'b0, rstn = 1'b0, hsel = 1'b0, hwrite = 1'b0, use3 = 1'b0, mon_cur = 1'b0;
  logic [31:0] haddr = 32'd0, hwdata = 32'd0, pend = 32'd0;
  logic [1:0] htrans = HTRANS_IDLE;
  logic [2:0] hsize = HSIZE_WORD;
  logic [31:0] rdata0, rdata3, rdata_m;
  logic rdyo0, rdyo3, resp0, resp3, rdyo_m, resp_m;
  int errs = 0, n_chk = 0, cyc = 0, acc_cyc = 0, lowcnt = 0, l0, c0;
  assign rdyo_m = use3 ? rdyo3 : rdyo0;
  assign resp_m = use3 ? resp3 : resp0;
  assign rdata_m = use3 ? rdata3 : rdata0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  mfp_ahb_ram_slave #(.ADDR_WIDTH(10), .DEPTH(512), .WAIT_STATES(0)) u0 (
    .HCLK(clk), .HRESETn(rstn), .HSEL(hsel & ~use3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0), .HPROT(4'h3), .HMASTLOCK(1'b0),
    .HWDATA(hwdata), .HREADY(rdyo0), .HRDATA(rdata0), .HREADYOUT(rdyo0), .HRESP(resp0)
  );
  mfp_ahb_ram_slave #(.ADDR_WIDTH(10), .DEPTH(512), .WAIT_STATES(3)) u3 (
    .HCLK(clk), .HRESETn(rstn), .HSEL(hsel & use3), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HBURST(3'd0), .HPROT(4'h3), .HMASTLOCK(1'b0),
    .HWDATA(hwdata), .HREADY(rdyo3), .HRDATA(rdata3), .HREADYOUT(rdyo3), .HRESP(resp3)
  );
  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction
  task automatic issue(input logic [1:0] tr, input logic wr, input logic [31:0] a, input logic [2:0] sz,
                       input logic [31:0] wd, input logic [31:0] ed, input logic er);
    int n = 0;
    htrans = tr; hwrite = wr; haddr = a; hsize = sz; hwdata = pend;
    if (tr[1]) sb.push_back('{wr, ed, er});
    do begin @(negedge clk); n++; end while (!rdyo_m && n < 50);
    if (!rdyo_m) begin errs++; $display("FAIL accept_timeout: hreadyout=%b required 1", rdyo_m); end
    @(posedge clk);
    #1 acc_cyc = cyc;
    pend = wd;
  endtask
  task automatic idle();
    issue(HTRANS_IDLE, 1'b0, 32'd0, HSIZE_WORD, 32'd0, 32'd0, 1'b0);
  endtask
  initial forever begin
    @(negedge clk);
    if (!rstn) begin
      mon_cur = 1'b0;
      sb.delete();
    end else begin
      if (mon_cur && rdyo_m) begin
        if (sb.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else begin
          e = sb.pop_front();
          chk("hresp", {31'd0, resp_m}, {31'd0, e.er});
          if (!e.wr && !e.er) chk("hrdata", rdata_m, e.d);
        end
      end
      if (!rdyo_m) lowcnt++;
      if (rdyo_m) mon_cur = hsel && htrans[1];
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_rdy0", {31'd0, rdyo0}, 32'd1);
    chk("rst_rdy3", {31'd0, rdyo3}, 32'd1);
    chk("rst_resp0", {31'd0, resp0}, 32'd0);
    chk("rst_resp3", {31'd0, resp3}, 32'd0);
    chk("rst_rdata0", rdata0, 32'd0);
    chk("rst_rdata3", rdata3, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1; hsel = 1'b1;
    l0 = lowcnt;
    issue(HTRANS_NONSEQ, 1'b1, 32'h10, HSIZE_WORD, 32'hDEADBEEF, 32'd0, 1'b0);
    issue(HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'd0, 32'hDEADBEEF, 1'b0);
    issue(HTRANS_NONSEQ, 1'b1, 32'h20, HSIZE_WORD, 32'h11223344, 32'd0, 1'b0);
    issue(HTRANS_NONSEQ, 1'b1, 32'h23, HSIZE_BYTE, 32'hAAEEEEEE, 32'd0, 1'b0);
    issue(HTRANS_SEQ, 1'b1, 32'h20, HSIZE_HALF, 32'hCCCC5566, 32'd0, 1'b0);
    issue(HTRANS_NONSEQ, 1'b0, 32'h20, HSIZE_WORD, 32'd0, 32'hAA225566, 1'b0);
    idle();
    issue(HTRANS_NONSEQ, 1'b0, 32'h20, HSIZE_WORD, 32'd0, 32'hAA225566, 1'b0);
    issue(HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'd0, 32'hDEADBEEF, 1'b0);
    idle();
    chk("ws0_stalls", lowcnt - l0, 32'd0);
    htrans = HTRANS_BUSY; hwrite = 1'b1; haddr = 32'h10; hwdata = 32'd0;
    @(negedge clk);
    chk("busy_rdy", {31'd0, rdyo_m}, 32'd1);
    chk("busy_resp", {31'd0, resp_m}, 32'd0);
    @(posedge clk);
    #1 htrans = HTRANS_IDLE; hwdata = 32'h0BAD0BAD;
    @(negedge clk);
    chk("idle_rdy", {31'd0, rdyo_m}, 32'd1);
    chk("idle_resp", {31'd0, resp_m}, 32'd0);
    @(posedge clk);
    #1 hwdata = 32'h0BAD0BAD;
    issue(HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'd0, 32'hDEADBEEF, 1'b0);
    idle();
`ifdef MFP_AHB_RAM_ERR_EN
    l0 = lowcnt;
    issue(HTRANS_NONSEQ, 1'b1, 32'h960, HSIZE_WORD, 32'h55555555, 32'd0, 1'b1);
    issue(HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD, 32'd0, 32'hDEADBEEF, 1'b0);
    issue(HTRANS_NONSEQ, 1'b1, 32'h20, 3'd3, 32'h66666666, 32'd0, 1'b1);
    issue(HTRANS_NONSEQ, 1'b0, 32'h20, HSIZE_WORD, 32'd0, 32'hAA225566, 1'b0);
    idle();
    chk("err_stalls", lowcnt - l0, 32'd2);
`else
    issue(HTRANS_NONSEQ, 1'b1, 32'h1960, HSIZE_WORD, 32'hCAFEF00D, 32'd0, 1'b0);
    issue(HTRANS_NONSEQ, 1'b0, 32'h960, HSIZE_WORD, 32'd0, 32'hCAFEF00D, 1'b0);
    issue(HTRANS_NONSEQ, 1'b1, 32'h30, 3'd3, 32'h01020304, 32'd0, 1'b0);
    issue(HTRANS_NONSEQ, 1'b0, 32'h30, HSIZE_WORD, 32'd0, 32'h01020304, 1'b0);
    idle();
    issue(HTRANS_NONSEQ, 1'b0, 32'h960, HSIZE_WORD, 32'd0, 32'hCAFEF00D, 1'b0);
    idle();
`endif
    use3 = 1'b1;
    issue(HTRANS_NONSEQ, 1'b1, 32'h40, HSIZE_WORD, 32'h0BADF00D, 32'd0, 1'b0);
    issue(HTRANS_NONSEQ, 1'b0, 32'h40, HSIZE_WORD, 32'd0, 32'h0BADF00D, 1'b0);
    idle();
    issue(HTRANS_NONSEQ, 1'b1, 32'h40, HSIZE_WORD, 32'h12345678, 32'd0, 1'b0);
    htrans = HTRANS_IDLE; hwdata = pend;
    @(posedge clk);
    #3 rstn = 1'b0;
    #1 chk("midrst_rdy", {31'd0, rdyo_m}, 32'd1);
    chk("midrst_resp", {31'd0, resp_m}, 32'd0);
    @(posedge clk);
    #1 rstn = 1'b1; pend = 32'd0;
    l0 = lowcnt;
    issue(HTRANS_NONSEQ, 1'b0, 32'h40, HSIZE_WORD, 32'd0, 32'h0BADF00D, 1'b0);
    c0 = acc_cyc;
    issue(HTRANS_NONSEQ, 1'b0, 32'h40, HSIZE_WORD, 32'd0, 32'h0BADF00D, 1'b0);
    chk("ws3_accept_gap", acc_cyc - c0, 32'd4);
    idle();
    chk("ws3_stalls", lowcnt - l0, 32'd6);
    chk("sb_drained", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, n_chk);
    $finish;
  end
endmodule
